// File: rtl/psr_branch_unit_pkg.sv
// Shared definitions for the PSR / branch resolution slice: flag positions,
// condition codes, standard flag-class masks and the branch FSM encoding.
package psr_branch_unit_pkg;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 2;
  localparam int FLAG_F = 5;
  localparam int FLAG_Z = 6;
  localparam int FLAG_N = 7;

  localparam logic [15:0] PSR_VALID_MASK = 16'h00E5;
  localparam logic [15:0] MASK_ADDSUB    = 16'h0021;
  localparam logic [15:0] MASK_CMP       = 16'h00C4;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_HI = 4'h4;
  localparam logic [3:0] COND_LS = 4'h5;
  localparam logic [3:0] COND_GT = 4'h6;
  localparam logic [3:0] COND_LE = 4'h7;
  localparam logic [3:0] COND_FS = 4'h8;
  localparam logic [3:0] COND_FC = 4'h9;
  localparam logic [3:0] COND_LO = 4'hA;
  localparam logic [3:0] COND_HS = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GE = 4'hD;
  localparam logic [3:0] COND_UC = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EVAL     = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

endpackage

// File: rtl/psr_branch_unit_if.sv
// Branch request / resolve / fetch-redirect bundle between decoder, branch unit and fetch.
interface psr_branch_unit_if #(
  parameter int WIDTH     = 16,
  parameter int DISP_BITS = 8
);
  logic                 br_valid;
  logic                 br_ready;
  logic                 br_is_jump;
  logic [3:0]           br_cond;
  logic [WIDTH-1:0]     br_pc;
  logic [DISP_BITS-1:0] br_disp;
  logic [WIDTH-1:0]     br_target;
  logic                 resolve_valid;
  logic                 resolve_taken;
  logic                 redirect_valid;
  logic                 redirect_ready;
  logic [WIDTH-1:0]     redirect_pc;

  modport master (
    output br_valid, br_is_jump, br_cond, br_pc, br_disp, br_target, redirect_ready,
    input  br_ready, resolve_valid, resolve_taken, redirect_valid, redirect_pc
  );

  modport slave (
    input  br_valid, br_is_jump, br_cond, br_pc, br_disp, br_target, redirect_ready,
    output br_ready, resolve_valid, resolve_taken, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/psr_cond_eval.sv
// Pure combinational condition-code evaluator against a PSR word; shared with
// the decoder's branch predictor.
module psr_cond_eval
  import psr_branch_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] psr,
  input  logic [3:0]       cond,
  output logic             taken
);

  logic c_s, l_s, f_s, z_s, n_s;
  logic unused_psr_bits_s;

  assign c_s = psr[FLAG_C];
  assign l_s = psr[FLAG_L];
  assign f_s = psr[FLAG_F];
  assign z_s = psr[FLAG_Z];
  assign n_s = psr[FLAG_N];
  assign unused_psr_bits_s = ^{psr[WIDTH-1:8], psr[4:3], psr[1]};

  // Map condition code to branch outcome
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z_s;
      COND_NE: taken = ~z_s;
      COND_CS: taken = c_s;
      COND_CC: taken = ~c_s;
      COND_HI: taken = l_s;
      COND_LS: taken = ~l_s;
      COND_GT: taken = n_s;
      COND_LE: taken = ~n_s;
      COND_FS: taken = f_s;
      COND_FC: taken = ~f_s;
      COND_LO: taken = ~l_s & ~z_s;
      COND_HS: taken = l_s | z_s;
      COND_LT: taken = ~n_s & ~z_s;
      COND_GE: taken = n_s | z_s;
      COND_UC: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/psr_branch_unit.sv
// Processor status register plus Bcond/Jcond resolution; taken branches are
// handed to fetch as a redirect PC over a valid/ready handshake.
module psr_branch_unit
  import psr_branch_unit_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DISP_BITS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] flags_in,
  input  logic             flags_we,
  input  logic [WIDTH-1:0] flags_mask,
  output logic [WIDTH-1:0] psr_out,
  psr_branch_unit_if.slave bus
);

  localparam logic [WIDTH-1:0] VALID_MASK = WIDTH'(PSR_VALID_MASK);

  logic [WIDTH-1:0] psr_r;
  state_e           state_r;
  logic [3:0]       cond_r;
  logic [WIDTH-1:0] target_r;
  logic             br_ready_r;
  logic             resolve_valid_r;
  logic             redirect_valid_r;
  logic [WIDTH-1:0] redirect_pc_r;
  logic             taken_s;
  logic [WIDTH-1:0] target_s;

  assign psr_out            = psr_r;
  assign bus.br_ready       = br_ready_r;
  assign bus.resolve_valid  = resolve_valid_r;
  assign bus.resolve_taken  = resolve_valid_r & taken_s;
  assign bus.redirect_valid = redirect_valid_r;
  assign bus.redirect_pc    = redirect_pc_r;

  // Branch target: sign-extended displacement wraps modulo 2^WIDTH
  always_comb begin
    target_s = '0;
    if (bus.br_is_jump) begin
      target_s = bus.br_target;
    end else begin
      target_s = bus.br_pc + {{(WIDTH-DISP_BITS){bus.br_disp[DISP_BITS-1]}}, bus.br_disp};
    end
  end

  psr_cond_eval #(.WIDTH(WIDTH)) u_cond_eval (
    .psr   (psr_r),
    .cond  (cond_r),
    .taken (taken_s)
  );

  // Masked PSR capture, independent of the branch FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psr_r <= '0;
    end else if (flags_we) begin
      psr_r <= (psr_r & ~flags_mask) | (flags_in & flags_mask & VALID_MASK);
    end
  end

  // Branch FSM: accept, evaluate against the registered PSR, offer redirect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r          <= ST_IDLE;
      cond_r           <= 4'h0;
      target_r         <= '0;
      br_ready_r       <= 1'b1;
      resolve_valid_r  <= 1'b0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= '0;
    end else begin
      resolve_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.br_valid) begin
            cond_r          <= bus.br_cond;
            target_r        <= target_s;
            br_ready_r      <= 1'b0;
            resolve_valid_r <= 1'b1;
            state_r         <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (taken_s) begin
            redirect_valid_r <= 1'b1;
            redirect_pc_r    <= target_r;
            state_r          <= ST_REDIRECT;
          end else begin
            br_ready_r <= 1'b1;
            state_r    <= ST_IDLE;
          end
        end
        ST_REDIRECT: begin
          if (bus.redirect_ready) begin
            redirect_valid_r <= 1'b0;
            br_ready_r       <= 1'b1;
            state_r          <= ST_IDLE;
          end
        end
        default: begin
          redirect_valid_r <= 1'b0;
          br_ready_r       <= 1'b1;
          state_r          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psr_branch_unit.sv
// Scoreboard bench for psr_branch_unit: directed scenarios then random traffic
// against a flag/condition reference model.
module tb_psr_branch_unit;
  import psr_branch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] flags_in;
  logic        flags_we;
  logic [15:0] flags_mask;
  logic [15:0] psr_out;

  psr_branch_unit_if #(.WIDTH(16), .DISP_BITS(8)) bus ();

  psr_branch_unit #(.WIDTH(16), .DISP_BITS(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flags_in   (flags_in),
    .flags_we   (flags_we),
    .flags_mask (flags_mask),
    .psr_out    (psr_out),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct { bit taken; int cyc; } res_t;
  res_t        res_q[$];
  logic [15:0] redir_q[$];

  // reference model state
  logic [15:0] psr_m;
  bit          eval_m, wait_m, pend_taken_m, last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_taken(input logic [15:0] p, input logic [3:0] cc);
    bit z, c, l, f, n, base;
    z = p[6]; c = p[0]; l = p[2]; f = p[5]; n = p[7];
    // codes come in complementary pairs: odd code inverts its even partner
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = l;
      3'd3: base = n;
      3'd4: base = f;
      3'd5: base = !l && !z;
      3'd6: base = !n && !z;
      default: base = 1'b1;
    endcase
    return base ^ cc[0];
  endfunction

  function automatic logic [15:0] ref_target(input bit jump, input logic [15:0] pc,
                                             input logic [7:0] disp, input logic [15:0] tgt);
    int d;
    if (jump) return tgt;
    d = int'(disp);
    if (d > 127) d = d - 256;
    return 16'((int'(pc) + d + 65536) % 65536);
  endfunction

  function automatic logic [15:0] ref_psr(input logic [15:0] p, input logic we,
                                          input logic [15:0] m, input logic [15:0] f);
    int flag_pos[5] = '{0, 2, 5, 6, 7};
    logic [15:0] r;
    r = p;
    if (we) foreach (flag_pos[i]) if (m[flag_pos[i]]) r[flag_pos[i]] = f[flag_pos[i]];
    return r;
  endfunction

  // advance one clock: model the edge, then check PSR and readiness after it
  task automatic tick();
    bit rdy, tk;
    rdy = !eval_m && !wait_m;
    psr_m = ref_psr(psr_m, flags_we, flags_mask, flags_in);
    last_acc = rdy && bus.br_valid;
    if (wait_m) begin
      if (bus.redirect_ready) wait_m = 1'b0;
    end else if (eval_m) begin
      eval_m = 1'b0;
      wait_m = pend_taken_m;
    end else if (bus.br_valid) begin
      tk = ref_taken(psr_m, bus.br_cond);
      eval_m = 1'b1;
      pend_taken_m = tk;
      res_q.push_back('{tk, cyc_cnt + 1});
      if (tk) redir_q.push_back(ref_target(bus.br_is_jump, bus.br_pc, bus.br_disp, bus.br_target));
    end
    @(posedge clk);
    #1;
    chk("psr_out", psr_out, psr_m);
    chk("br_ready", bus.br_ready, !eval_m && !wait_m);
  endtask

  task automatic set_flags(input logic we, input logic [15:0] m, input logic [15:0] f);
    flags_we = we; flags_mask = m; flags_in = f;
  endtask

  task automatic issue(input bit jump, input logic [3:0] cc, input logic [15:0] pc,
                       input logic [7:0] disp, input logic [15:0] tgt);
    bus.br_valid = 1'b1; bus.br_is_jump = jump; bus.br_cond = cc;
    bus.br_pc = pc; bus.br_disp = disp; bus.br_target = tgt;
  endtask

  // monitor: pops expectations whenever the DUT resolves or hands off a redirect
  bit          prev_v, prev_r;
  logic [15:0] prev_pc;
  int          redir_due = -1;
  res_t        mon_e;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_v = 1'b0; prev_r = 1'b0; redir_due = -1;
    end else begin
      if (redir_due == cyc_cnt) begin
        chk("redirect_offer_cycle", bus.redirect_valid, 1'b1);
        redir_due = -1;
      end
      if (bus.resolve_valid) begin
        chk("resolve_expected", res_q.size() != 0, 1'b1);
        if (res_q.size() != 0) begin
          mon_e = res_q.pop_front();
          chk("resolve_taken", bus.resolve_taken, mon_e.taken);
          chk("resolve_cycle", cyc_cnt, mon_e.cyc);
          if (mon_e.taken) redir_due = cyc_cnt + 1;
        end
      end
      if (prev_v && !prev_r) begin
        chk("redirect_hold_valid", bus.redirect_valid, 1'b1);
        chk("redirect_hold_pc", bus.redirect_pc, prev_pc);
      end
      if (bus.redirect_valid && bus.redirect_ready) begin
        chk("redirect_expected", redir_q.size() != 0, 1'b1);
        if (redir_q.size() != 0) chk("redirect_pc", bus.redirect_pc, redir_q.pop_front());
      end
      prev_v = bus.redirect_valid; prev_r = bus.redirect_ready; prev_pc = bus.redirect_pc;
    end
  end

  initial begin
    reset_n = 1'b0;
    set_flags(1'b0, 16'h0000, 16'h0000);
    bus.br_valid = 1'b0; bus.br_is_jump = 1'b0; bus.br_cond = 4'h0;
    bus.br_pc = 16'h0000; bus.br_disp = 8'h00; bus.br_target = 16'h0000;
    bus.redirect_ready = 1'b1;
    psr_m = 16'h0000; eval_m = 1'b0; wait_m = 1'b0; pend_taken_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_psr", psr_out, 16'h0000);
    chk("reset_br_ready", bus.br_ready, 1'b1);
    chk("reset_resolve_valid", bus.resolve_valid, 1'b0);
    chk("reset_resolve_taken", bus.resolve_taken, 1'b0);
    chk("reset_redirect_valid", bus.redirect_valid, 1'b0);
    chk("reset_redirect_pc", bus.redirect_pc, 16'h0000);
    reset_n = 1'b1;

    // masked PSR writes
    set_flags(1'b1, 16'h00E5, 16'hFFFF); tick();
    chk("psr_all_valid", psr_out, 16'h00E5);
    set_flags(1'b1, 16'h0041, 16'h0000); tick();
    chk("psr_partial_mask", psr_out, 16'h00A4);

    // Bcond EQ taken, negative displacement
    set_flags(1'b1, MASK_CMP, 16'h0040); tick();
    set_flags(1'b0, 16'h0000, 16'h0000);
    issue(1'b0, COND_EQ, 16'h0010, 8'hFC, 16'h0000); tick();
    bus.br_valid = 1'b0;
    chk("eq_resolve_valid", bus.resolve_valid, 1'b1);
    chk("eq_resolve_taken", bus.resolve_taken, 1'b1);
    tick();
    chk("eq_redirect_valid", bus.redirect_valid, 1'b1);
    chk("eq_redirect_pc", bus.redirect_pc, 16'h000C);
    tick();
    chk("eq_ready_back", bus.br_ready, 1'b1);
    chk("eq_redirect_done", bus.redirect_valid, 1'b0);

    // Bcond NE not taken
    issue(1'b0, COND_NE, 16'h0020, 8'h10, 16'h0000); tick();
    bus.br_valid = 1'b0;
    chk("ne_resolve_valid", bus.resolve_valid, 1'b1);
    chk("ne_resolve_taken", bus.resolve_taken, 1'b0);
    tick();
    chk("ne_ready_back", bus.br_ready, 1'b1);
    chk("ne_no_redirect", bus.redirect_valid, 1'b0);

    // flag write on the accept edge counts, on the EVAL edge does not
    set_flags(1'b1, 16'h0040, 16'h0000); tick();
    set_flags(1'b1, 16'h0040, 16'h0040);
    issue(1'b1, COND_EQ, 16'h1234, 8'h00, 16'hABCD); tick();
    bus.br_valid = 1'b0;
    set_flags(1'b1, 16'h0040, 16'h0000);
    chk("jeq_resolve_taken", bus.resolve_taken, 1'b1);
    tick();
    set_flags(1'b0, 16'h0000, 16'h0000);
    chk("jeq_redirect_pc", bus.redirect_pc, 16'hABCD);
    tick();

    // wrapping target, fetch back-pressure, requests held while busy
    bus.redirect_ready = 1'b0;
    issue(1'b0, COND_UC, 16'hFFFE, 8'h05, 16'h0000); tick();
    issue(1'b1, COND_UC, 16'h0000, 8'h00, 16'h5555); tick();
    for (int i = 0; i < 4; i++) begin
      chk("wrap_redirect_valid", bus.redirect_valid, 1'b1);
      chk("wrap_redirect_pc", bus.redirect_pc, 16'h0003);
      tick();
    end
    bus.br_valid = 1'b0;
    bus.redirect_ready = 1'b1;
    tick();
    chk("wrap_redirect_done", bus.redirect_valid, 1'b0);

    // asynchronous reset while a redirect is pending
    bus.redirect_ready = 1'b0;
    set_flags(1'b1, 16'h00E5, 16'h00FF);
    issue(1'b1, COND_UC, 16'h0000, 8'h00, 16'h0BAD); tick();
    bus.br_valid = 1'b0;
    set_flags(1'b0, 16'h0000, 16'h0000);
    tick();
    chk("rst_pre_redirect_valid", bus.redirect_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_redirect_valid", bus.redirect_valid, 1'b0);
    chk("rst_async_psr", psr_out, 16'h0000);
    psr_m = 16'h0000; eval_m = 1'b0; wait_m = 1'b0;
    res_q.delete(); redir_q.delete();
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    bus.redirect_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_ready", bus.br_ready, 1'b1);
    chk("rst_release_redirect", bus.redirect_valid, 1'b0);
    repeat (3) tick();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 2))
        0: set_flags(1'($urandom), MASK_ADDSUB, 16'($urandom));
        1: set_flags(1'($urandom), MASK_CMP, 16'($urandom));
        default: set_flags(1'($urandom), 16'($urandom), 16'($urandom));
      endcase
      if (!bus.br_valid && ($urandom_range(0, 1) == 1))
        issue(1'($urandom), 4'($urandom), 16'($urandom), 8'($urandom), 16'($urandom));
      bus.redirect_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (last_acc) bus.br_valid = 1'b0;
    end

    bus.br_valid = 1'b0;
    bus.redirect_ready = 1'b1;
    set_flags(1'b0, 16'h0000, 16'h0000);
    repeat (6) tick();
    chk("resolve_queue_drained", res_q.size(), 0);
    chk("redirect_queue_drained", redir_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psr_branch_unit.md
Name: psr_branch_unit

Overview:
- Consumer end of the ALU flag interface. Holds the Processor Status Register (PSR) and captures ALU flag outputs under a per-bit write mask.
- Resolves Bcond (PC-relative displacement) and Jcond (register target) instructions against the PSR.
- Hands a redirect PC to instruction fetch through a valid/ready handshake.
- Sits between the ALU/decoder and the fetch stage.

Parameters:
- WIDTH, 16, datapath, PC and PSR width.
- DISP_BITS, 8, width of the signed Bcond displacement.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flags_in  in  WIDTH  ALU flag word; bit positions C=0, L=2, F=5, Z=6, N=7; all other bits ignored.
- flags_we  in  1  PSR write enable.
- flags_mask  in  WIDTH  per-bit PSR update mask (ADD/SUB: C,F; CMP: N,Z,L).
- br_valid  in  1  branch request valid.
- br_ready  out  1  unit can accept a request.
- br_is_jump  in  1  0 = Bcond (displacement), 1 = Jcond (register target).
- br_cond  in  4  condition code.
- br_pc  in  WIDTH  PC of the branch instruction.
- br_disp  in  DISP_BITS  signed displacement (Bcond only).
- br_target  in  WIDTH  absolute target (Jcond only).
- resolve_valid  out  1  one-cycle pulse: branch resolved.
- resolve_taken  out  1  outcome; qualified by resolve_valid.
- redirect_valid  out  1  redirect PC offered to fetch.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_pc  out  WIDTH  target PC.
- psr_out  out  WIDTH  current PSR; unused bits read 0.

Behaviour:
- Reset (async, reset_n=0): PSR=0, state=IDLE, br_ready=1, resolve_valid=0, resolve_taken=0, redirect_valid=0, redirect_pc=0. Reset mid-operation abandons any branch; no redirect is issued afterwards.
- PSR update: on each edge with flags_we=1, PSR <= (PSR & ~flags_mask) | (flags_in & flags_mask & 16'h00E5). Flag writes are independent of FSM state.
- FSM states: IDLE, EVAL, REDIRECT.
- IDLE: br_ready=1. On br_valid=1, capture cond, kind, and the computed target, then go to EVAL.
  - Bcond target = br_pc + sign_extend(br_disp), modulo 2^WIDTH (wraps).
  - Jcond target = br_target.
- EVAL: br_ready=0. Condition is evaluated against the registered PSR, which includes any write made on the acceptance edge. A flag write on the EVAL edge does not affect this branch.
  - Not taken: resolve_valid=1, resolve_taken=0 for that cycle; next state IDLE.
  - Taken: resolve_valid=1, resolve_taken=1; load redirect_pc; next state REDIRECT.
- REDIRECT: redirect_valid=1, redirect_pc stable until the handshake edge (redirect_valid & redirect_ready), then IDLE. redirect_ready asserted continuously gives exactly one transfer cycle.
- Latency: accept edge -> resolve 1 cycle later. Taken branch -> redirect offered the same cycle as resolve_valid+1. Minimum 3 cycles per taken branch, 2 per not-taken.
- br_ready=0 outside IDLE. Requests in EVAL/REDIRECT are not accepted; the requester holds them.
- Condition codes:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 HI: L
  - 5 LS: !L
  - 6 GT: N
  - 7 LE: !N
  - 8 FS: F
  - 9 FC: !F
  - A LO: !L & !Z
  - B HS: L | Z
  - C LT: !N & !Z
  - D GE: N | Z
  - E UC: 1
  - F never: 0

Decomposition:
- Shared package contains:
  - flag bit indices (C/L/F/Z/N), PSR valid-bit mask 16'h00E5
  - 4-bit condition-code constants
  - FSM state encoding
  - standard flag masks for the ADD/SUB and CMP classes
- One combinational sub-module, psr_cond_eval (psr, cond -> taken), reusable by the decoder for prediction.

Test Plan:
- Reset then flags_we=1, mask=00E5, flags_in=FFFF -> psr_out=00E5. Then mask=0041, flags_in=0000 -> psr_out=00A4.
- PSR Z=1; Bcond EQ, br_pc=0010, disp=8'hFC, redirect_ready=1 -> resolve_taken=1 one cycle after accept; redirect_pc=000C valid next cycle; br_ready back high the cycle after.
- PSR Z=1; Bcond NE -> resolve_valid=1, resolve_taken=0, redirect_valid never asserted, FSM in IDLE 2 cycles after accept.
- Flag write Z=1 on the accept edge with Jcond EQ, target=ABCD -> taken, redirect_pc=ABCD. Flag write clearing Z on the EVAL edge -> outcome unchanged.
- Bcond UC, br_pc=FFFE, disp=8'h05 -> redirect_pc=0003 (wrap). redirect_ready low 4 cycles -> redirect_valid and redirect_pc held stable; br_valid ignored throughout.
- reset_n low while in REDIRECT -> redirect_valid=0 immediately (async), PSR=0, br_ready=1 after release.
